// File: rtl/ex_stage_mc.sv
// Execute stage with a registered EX/MEM output slot and ready/valid on both sides.
// Single-cycle ALU ops write the output register at accept; shifts with a non-zero
// amount iterate one bit per cycle and complete after shamt cycles.
module ex_stage_mc #(
  parameter int unsigned DW     = 16,
  parameter int unsigned RW     = 4,
  parameter int unsigned SP_IDX = 15,
  parameter int unsigned SAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_op,
  input  logic                  alu_src,
  input  logic [$clog2(DW)-1:0] shamt,
  input  logic [DW-1:0]         rd_data_1,
  input  logic [DW-1:0]         rd_data_2,
  input  logic [DW-1:0]         imm,
  input  logic                  load_half,
  input  logic                  half_spec,
  input  logic [DW/2-1:0]       half_imm,
  input  logic                  reg_wr,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  input  logic                  mem_to_reg,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  halt,
  input  logic [DW-1:0]         pc,
  input  logic [RW-1:0]         reg_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         result,
  output logic [DW-1:0]         sw_data,
  output logic [RW-1:0]         reg_rd_o,
  output logic                  reg_wr_o,
  output logic                  mem_wr_o,
  output logic                  mem_rd_o,
  output logic                  mem_to_reg_o,
  output logic                  call_o,
  output logic                  ret_o,
  output logic                  halt_o,
  output logic [2:0]            flags,
  output logic                  busy
);

  localparam int unsigned SW = $clog2(DW);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpNor  = 3'b011;
  localparam logic [2:0] OpPass = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StWait} state_e;

  state_e          state_q, state_d;
  logic            halted_q, halted_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   result_q, result_d;
  logic [DW-1:0]   sw_data_q, sw_data_d;
  logic [RW-1:0]   reg_rd_q, reg_rd_d;
  logic [6:0]      sb_q, sb_d;
  logic [2:0]      flags_q, flags_d;
  // Pending shift operand, remaining count, direction and captured sideband
  logic [DW-1:0]   sh_val_q, sh_val_d;
  logic [SW-1:0]   sh_cnt_q, sh_cnt_d;
  logic [1:0]      sh_op_q, sh_op_d;
  logic [DW-1:0]   p_sw_q, p_sw_d;
  logic [RW-1:0]   p_rd_q, p_rd_d;
  logic [6:0]      p_sb_q, p_sb_d;

  logic [DW-1:0]   op_b, sum, diff, alu_res, sh_next;
  logic            ovf, alu_arith, alu_fupd;
  logic [2:0]      alu_flags;
  logic [6:0]      sb_in;
  logic [DW-1:0]   sw_in;
  logic [RW-1:0]   rd_in;
  logic            slot_free, accept, multi;
  logic            wr, wr_fupd;
  logic [DW-1:0]   wr_res, wr_sw;
  logic [RW-1:0]   wr_rd;
  logic [6:0]      wr_sb;
  logic [2:0]      wr_flags;

  assign sb_in = {reg_wr, mem_wr, mem_rd, mem_to_reg, call, ret, halt};
  assign sw_in = call ? pc : rd_data_2;
  assign rd_in = (call || ret) ? RW'(SP_IDX) : reg_rd;

  // Single-cycle ALU / load-half datapath with overflow detection and optional saturation
  always_comb begin
    op_b      = alu_src ? imm : rd_data_2;
    sum       = rd_data_1 + op_b;
    diff      = rd_data_1 - op_b;
    ovf       = 1'b0;
    alu_arith = 1'b0;
    alu_fupd  = 1'b0;
    alu_res   = op_b;
    if (load_half) begin
      alu_res = half_spec ? {rd_data_2[DW-1:DW/2], half_imm} : {half_imm, rd_data_2[DW/2-1:0]};
    end else begin
      case (alu_op)
        OpAdd: begin
          ovf       = (rd_data_1[DW-1] == op_b[DW-1]) && (sum[DW-1] != rd_data_1[DW-1]);
          alu_res   = sum;
          alu_arith = 1'b1;
          alu_fupd  = 1'b1;
        end
        OpSub: begin
          ovf       = (rd_data_1[DW-1] != op_b[DW-1]) && (diff[DW-1] != rd_data_1[DW-1]);
          alu_res   = diff;
          alu_arith = 1'b1;
          alu_fupd  = 1'b1;
        end
        OpAnd: begin
          alu_res  = rd_data_1 & op_b;
          alu_fupd = 1'b1;
        end
        OpNor: begin
          alu_res  = ~(rd_data_1 | op_b);
          alu_fupd = 1'b1;
        end
        OpPass: alu_res = op_b;
        // Zero-amount shifts pass A through and still update Z
        default: begin
          alu_res  = rd_data_1;
          alu_fupd = 1'b1;
        end
      endcase
      // Clamp direction follows the sign of A: only a non-negative A can overflow upwards
      if (ovf && (SAT != 0)) begin
        alu_res = rd_data_1[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
    alu_flags = {alu_res == '0, alu_arith & ovf, alu_arith & alu_res[DW-1]};
  end

  // One-bit step of the iterative shifter
  always_comb begin
    case (sh_op_q)
      2'b00:   sh_next = {sh_val_q[DW-2:0], 1'b0};
      2'b01:   sh_next = {1'b0, sh_val_q[DW-1:1]};
      default: sh_next = {sh_val_q[DW-1], sh_val_q[DW-1:1]};
    endcase
  end

  // Handshake, FSM next state and output-register update
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (state_q == StIdle) && slot_free && !halted_q && !flush;
    accept    = in_valid && in_ready;
    multi     = !load_half && alu_op[2] && (alu_op != OpPass) && (shamt != '0);

    state_d     = state_q;
    halted_d    = halted_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sw_data_d   = sw_data_q;
    reg_rd_d    = reg_rd_q;
    sb_d        = sb_q;
    flags_d     = flags_q;
    sh_val_d    = sh_val_q;
    sh_cnt_d    = sh_cnt_q;
    sh_op_d     = sh_op_q;
    p_sw_d      = p_sw_q;
    p_rd_d      = p_rd_q;
    p_sb_d      = p_sb_q;

    wr       = 1'b0;
    wr_fupd  = 1'b0;
    wr_res   = alu_res;
    wr_sw    = sw_in;
    wr_rd    = rd_in;
    wr_sb    = sb_in;
    wr_flags = alu_flags;

    if (accept && halt) halted_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (multi) begin
            sh_val_d = rd_data_1;
            sh_cnt_d = shamt;
            sh_op_d  = alu_op[1:0];
            p_sw_d   = sw_in;
            p_rd_d   = rd_in;
            p_sb_d   = sb_in;
            state_d  = StShift;
          end else begin
            wr      = 1'b1;
            wr_fupd = alu_fupd;
          end
        end
      end
      StShift: begin
        sh_val_d = sh_next;
        sh_cnt_d = sh_cnt_q - 1'b1;
        if (sh_cnt_q == SW'(1)) begin
          if (slot_free) begin
            wr       = 1'b1;
            wr_fupd  = 1'b1;
            wr_res   = sh_next;
            wr_sw    = p_sw_q;
            wr_rd    = p_rd_q;
            wr_sb    = p_sb_q;
            wr_flags = {sh_next == '0, 2'b00};
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (slot_free) begin
          wr       = 1'b1;
          wr_fupd  = 1'b1;
          wr_res   = sh_val_q;
          wr_sw    = p_sw_q;
          wr_rd    = p_rd_q;
          wr_sb    = p_sb_q;
          wr_flags = {sh_val_q == '0, 2'b00};
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush kills both the in-flight shift and the output slot, with no flag update
    if (flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else if (wr) begin
      out_valid_d = 1'b1;
      result_d    = wr_res;
      sw_data_d   = wr_sw;
      reg_rd_d    = wr_rd;
      sb_d        = wr_sb;
      if (wr_fupd) flags_d = wr_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sw_data_q   <= '0;
      reg_rd_q    <= '0;
      sb_q        <= '0;
      flags_q     <= '0;
      sh_val_q    <= '0;
      sh_cnt_q    <= '0;
      sh_op_q     <= '0;
      p_sw_q      <= '0;
      p_rd_q      <= '0;
      p_sb_q      <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sw_data_q   <= sw_data_d;
      reg_rd_q    <= reg_rd_d;
      sb_q        <= sb_d;
      flags_q     <= flags_d;
      sh_val_q    <= sh_val_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_op_q     <= sh_op_d;
      p_sw_q      <= p_sw_d;
      p_rd_q      <= p_rd_d;
      p_sb_q      <= p_sb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sw_data   = sw_data_q;
  assign reg_rd_o  = reg_rd_q;
  assign {reg_wr_o, mem_wr_o, mem_rd_o, mem_to_reg_o, call_o, ret_o, halt_o} = sb_q;
  assign flags     = flags_q;
  assign busy      = (state_q == StShift);

endmodule
